// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory signal bundle for the shared-SRAM arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [DATA_WIDTH-1:0] if_rdata;
  logic                  if_ack;
  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [DATA_WIDTH-1:0] dm_wdata;
  logic [DATA_WIDTH-1:0] dm_rdata;
  logic                  dm_ack;
  logic                  mem_cs;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  busy;

  // slave: the arbiter's view; master: requesters plus memory around it
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ack, dm_rdata, dm_ack, mem_cs, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ack, dm_rdata, dm_ack, mem_cs, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one single-port SRAM between IF and DM
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;
  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  logic [1:0]            state;
  logic                  last_grant_dm;
  logic                  grant_dm;
  logic [3:0]            wait_cnt;
  logic                  cap_we;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic [DATA_WIDTH-1:0] if_rdata_q;
  logic [DATA_WIDTH-1:0] dm_rdata_q;
  logic                  pick_dm;

  // DM wins when alone, or on a tie when IF was served last
  assign pick_dm = bus.dm_req && (!bus.if_req || !last_grant_dm);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      last_grant_dm <= 1'b0;
      grant_dm      <= 1'b0;
      wait_cnt      <= 4'd0;
      cap_we        <= 1'b0;
      cap_addr      <= '0;
      cap_wdata     <= '0;
      if_rdata_q    <= '0;
      dm_rdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.if_req || bus.dm_req) begin
            grant_dm      <= pick_dm;
            last_grant_dm <= pick_dm;
            cap_we        <= pick_dm && bus.dm_we;
            cap_addr      <= pick_dm ? bus.dm_addr : bus.if_addr;
            cap_wdata     <= pick_dm ? bus.dm_wdata : '0;
            wait_cnt      <= 4'd0;
            state         <= ACCESS;
          end
        end
        ACCESS: begin
          wait_cnt <= wait_cnt + 4'd1;
          if (wait_cnt == LAST_CNT) begin
            state <= RESP;
            // read data is taken on the last ACCESS edge so it is visible with the ack
            if (!cap_we) begin
              if (grant_dm) dm_rdata_q <= bus.mem_rdata;
              else          if_rdata_q <= bus.mem_rdata;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_cs    = (state == ACCESS);
  assign bus.mem_we    = (state == ACCESS) && cap_we;
  assign bus.mem_addr  = (state == ACCESS) ? cap_addr  : '0;
  assign bus.mem_wdata = (state == ACCESS) ? cap_wdata : '0;
  assign bus.if_ack    = (state == RESP) && !grant_dm;
  assign bus.dm_ack    = (state == RESP) && grant_dm;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic clock;
  logic reset;
  int   passed;
  int   failed;
  int   total;

  logic        pre_we;
  logic [9:0]  pre_addr;
  logic [31:0] pre_data;
  logic [31:0] mem [0:1023];

  mem_port_arbiter_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bus ();

  mem_port_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_CYCLES(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // synchronous SRAM model: one-cycle read latency, writes while cs&we
  always @(posedge clock) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bus.mem_cs) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 1'b0;
  endtask

  initial begin
    int w;
    passed = 0; failed = 0; total = 0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    reset = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;

    preload(10'h010, 32'h1234_5678);
    preload(10'h020, 32'hA5A5_0020);
    preload(10'h030, 32'h0BAD_0030);
    preload(10'h001, 32'h1111_0001);
    preload(10'h3FF, 32'h3FF3_FFFF);

    check("rst_mem_cs",   {31'd0, bus.mem_cs}, 32'd0);
    check("rst_busy",     {31'd0, bus.busy},   32'd0);
    check("rst_acks",     {30'd0, bus.if_ack, bus.dm_ack}, 32'd0);
    check("rst_if_rdata", bus.if_rdata, 32'd0);
    check("rst_dm_rdata", bus.dm_rdata, 32'd0);
    check("rst_mem_addr", {22'd0, bus.mem_addr}, 32'd0);
    reset = 1'b0;

    // single IF read, latency check
    bus.if_req = 1'b1; bus.if_addr = 10'h010;
    tick();
    check("t1_c1_cs",   {31'd0, bus.mem_cs}, 32'd1);
    check("t1_c1_addr", {22'd0, bus.mem_addr}, 32'h010);
    tick();
    check("t1_c2_cs",   {31'd0, bus.mem_cs}, 32'd1);
    check("t1_c2_ack",  {31'd0, bus.if_ack}, 32'd0);
    tick();
    check("t1_c3_ack",  {31'd0, bus.if_ack}, 32'd1);
    check("t1_c3_data", bus.if_rdata, 32'h1234_5678);
    check("t1_c3_cs",   {31'd0, bus.mem_cs}, 32'd0);
    bus.if_req = 1'b0;
    tick();
    check("t1_c4_busy", {31'd0, bus.busy},   32'd0);
    check("t1_c4_ack",  {31'd0, bus.if_ack}, 32'd0);
    check("t1_c4_hold", bus.if_rdata, 32'h1234_5678);

    // simultaneous requests after reset: DM first
    reset = 1'b1; #1; reset = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 10'h030;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 10'h020;
    for (int c = 1; c <= 7; c++) begin
      tick();
      check($sformatf("t2_c%0d_dm_ack", c), {31'd0, bus.dm_ack}, {31'd0, c == 3});
      check($sformatf("t2_c%0d_if_ack", c), {31'd0, bus.if_ack}, {31'd0, c == 7});
      if (c == 3) begin
        check("t2_dm_data", bus.dm_rdata, 32'hA5A5_0020);
        bus.dm_req = 1'b0;
      end
      if (c == 7) begin
        check("t2_if_data", bus.if_rdata, 32'h0BAD_0030);
        bus.if_req = 1'b0;
      end
    end
    tick();

    // continuous contention: strict alternation, one access between grants
    bus.if_req = 1'b1; bus.dm_req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      w = 0;
      do begin
        tick();
        w++;
      end while (!(bus.if_ack || bus.dm_ack) && w < 12);
      check($sformatf("t3_k%0d_seen", k), {31'd0, bus.if_ack || bus.dm_ack}, 32'd1);
      check($sformatf("t3_k%0d_order", k), {31'd0, bus.dm_ack}, {31'd0, (k % 2) == 0});
      check($sformatf("t3_k%0d_gap", k), 32'(w), (k == 0) ? 32'd3 : 32'd4);
      if ((k % 2) == 0) check($sformatf("t3_k%0d_dm", k), bus.dm_rdata, 32'hA5A5_0020);
      else              check($sformatf("t3_k%0d_if", k), bus.if_rdata, 32'h0BAD_0030);
    end
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    tick();

    // DM write then read back
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 10'h155; bus.dm_wdata = 32'hDEAD_BEEF;
    for (int c = 1; c <= 3; c++) begin
      tick();
      check($sformatf("t4w_c%0d_we", c), {31'd0, bus.mem_we}, {31'd0, c != 3});
      check($sformatf("t4w_c%0d_ack", c), {31'd0, bus.dm_ack}, {31'd0, c == 3});
    end
    check("t4w_if_keep", bus.if_rdata, 32'h0BAD_0030);
    bus.dm_req = 1'b0;
    tick();
    check("t4w_mem", mem[10'h155], 32'hDEAD_BEEF);
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_wdata = 32'h0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      check($sformatf("t4r_c%0d_we", c), {31'd0, bus.mem_we}, 32'd0);
    end
    check("t4r_ack",     {31'd0, bus.dm_ack}, 32'd1);
    check("t4r_data",    bus.dm_rdata, 32'hDEAD_BEEF);
    check("t4r_if_keep", bus.if_rdata, 32'h0BAD_0030);
    bus.dm_req = 1'b0;
    tick();

    // address change after grant is ignored
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 10'h001;
    tick();
    bus.dm_addr = 10'h3FF;
    check("t5_c1_addr", {22'd0, bus.mem_addr}, 32'h001);
    tick();
    check("t5_c2_addr", {22'd0, bus.mem_addr}, 32'h001);
    tick();
    check("t5_ack",     {31'd0, bus.dm_ack}, 32'd1);
    check("t5_data",    bus.dm_rdata, 32'h1111_0001);
    check("t5_addr0",   {22'd0, bus.mem_addr}, 32'd0);
    bus.dm_req = 1'b0;
    tick();

    // reset during the second ACCESS cycle of an IF read
    bus.if_req = 1'b1; bus.if_addr = 10'h010;
    tick();
    tick();
    check("t6_pre_cs", {31'd0, bus.mem_cs}, 32'd1);
    reset = 1'b1;
    #1;
    check("t6_rst_cs",   {31'd0, bus.mem_cs}, 32'd0);
    check("t6_rst_busy", {31'd0, bus.busy},   32'd0);
    check("t6_rst_if",   bus.if_rdata, 32'd0);
    check("t6_rst_dm",   bus.dm_rdata, 32'd0);
    tick();
    check("t6_rst_ack",  {31'd0, bus.if_ack}, 32'd0);
    reset = 1'b0;
    tick();
    check("t6_c1_ack",  {31'd0, bus.if_ack}, 32'd0);
    tick();
    check("t6_c2_ack",  {31'd0, bus.if_ack}, 32'd0);
    tick();
    check("t6_c3_ack",  {31'd0, bus.if_ack}, 32'd1);
    check("t6_c3_data", bus.if_rdata, 32'h1234_5678);
    bus.if_req = 1'b0;
    tick();
    check("t6_idle", {31'd0, bus.busy}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
